ifetch_queue: RTL and testbench
===============================

Name: ifetch_queue

Overview:
- Instruction fetch stage, directly upstream of the decode stage.
- Owns the PC and issues in-order requests to a variable-latency instruction memory.
- Buffers returned 48-bit instructions with their next-PC in a small queue and presents them to decode, which flops them when not stalled.
- Handles flow-change redirects from EX and halt, delivering NOP bubbles (48'h0, LLB R0,#0) whenever no instruction is available.

Parameters:
- PC_W, 16, PC width (word address, one instruction per word)
- DEPTH, 4, queue entries; power of 2, minimum 2
- RESET_PC, 16'h0000, PC loaded at reset
- NOP_INSTR, 48'h0, bubble instruction presented when queue empty

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- stall_IM_ID  in  1  decode not consuming this cycle; hold head
- flow_change_ID_EX  in  1  taken branch/jump resolved in EX; redirect
- dst_ID_EX  in  PC_W  redirect target, valid with flow_change_ID_EX
- hlt_fetch  in  1  halt decoded; stop issuing requests (sticky until reset)
- im_req  out  1  request valid
- im_addr  out  PC_W  request address
- im_gnt  in  1  memory accepts request this cycle
- im_rvalid  in  1  response data valid, in request order
- im_rdata  in  48  instruction word
- instr  out  48  instruction to decode (queue head or NOP_INSTR)
- nxt_pc  out  PC_W  address of instr + 1; 0 when NOP presented
- instr_vld  out  1  head is a real instruction

Behaviour:
- Reset: pc=RESET_PC, queue empty, outstanding=0, discard=0, halted=0; im_req=0, instr=NOP_INSTR, nxt_pc=0, instr_vld=0.
- Queue entry = {im_rdata, request address+1}. Count range 0..DEPTH; wrap-around pointers of log2(DEPTH) bits plus count.
- Issue rule: im_req = !halted & !flow_change_ID_EX & (count + outstanding < DEPTH). im_addr = pc.
  - Once raised, im_req/im_addr are held stable until im_gnt, unless a redirect occurs.
  - On im_req&im_gnt: pc <= pc+1 (mod 2^PC_W), outstanding++.
- Response: on im_rvalid, outstanding-- (saturate never needed; underflow is a checker error).
  - If discard>0: drop data, discard--.
  - Else push into queue. The credit rule guarantees no overflow; push when full is an assertion failure.
- Pop: when !stall_IM_ID & count>0, head popped at clock edge. Output is combinational from head, so decode flops that entry.
- Empty: instr=NOP_INSTR, instr_vld=0, nothing popped.
- Same-cycle push and pop into an empty queue: the response is written; it appears at the head next cycle (no bypass).
- Redirect (flow_change_ID_EX=1):
  - pc <= dst_ID_EX; queue flushed (count=0).
  - discard <= outstanding_next + discard_next, where _next includes a grant and a response in the same cycle.
    - A grant in the redirect cycle cannot occur (im_req forced low).
    - A response in the redirect cycle is dropped.
  - Pop is suppressed. Decode squashes the current slot itself.
  - First redirected request issues the following cycle.
- Halt: hlt_fetch sets halted. No further requests; in-flight responses still return and are queued/dropped normally.
- Redirect and hlt_fetch in the same cycle: both take effect; pc updated, halted set.
- Back-to-back redirects: each reloads pc and accumulates discard correctly.
- Latency: minimum grant-to-rvalid 1 cycle. Redirect to first new instruction at decode input is 1 + memory latency + 1 cycles.
- Async reset mid-transaction: state cleared. The memory model must also reset; responses after reset are undefined.

Decomposition:
- Shared package/include: NOP_INSTR encoding, instruction width (48), PC width, RESET_PC. These are alongside existing opcode params in common_params.inc.
- One sub-module: ifq_fifo (parameterised DEPTH x (48+PC_W) synchronous FIFO with flush, count, full/empty). Top holds PC, issue, outstanding/discard counters.

Test Plan:
- Reset, 1-cycle memory, no stall -> im_addr 0,1,2,3...; instr sequence matches memory words; instr_vld=1 from cycle 3; nxt_pc = addr+1.
- Hold stall_IM_ID high 6 cycles, 1-cycle memory -> at most 4 requests granted beyond consumed; instr/nxt_pc stable during stall; no overflow; resume delivers all in order.
- Memory latency 3, im_gnt withheld 2 cycles -> im_addr held stable while im_req=1; in-order delivery; NOP with instr_vld=0 while empty.
- Redirect to 16'h0040 with 3 outstanding (latency 3) -> 3 responses dropped; queue flushed; next real instr is word 0x40 with nxt_pc=0x41.
- Redirect coincident with an im_rvalid, then a second redirect to 0x0080 two cycles later -> all stale data dropped; first delivered is word 0x80.
- hlt_fetch at pc=5 with 2 outstanding -> no further im_req; words 3,4 delivered, then NOP forever.

Source files
------------

// File: rtl/ifetch_queue_pkg.sv
// Shared fetch constants: instruction/PC widths, reset PC, bubble encoding.
// Kept alongside the opcode parameters so decode and fetch agree on NOP.
package ifetch_queue_pkg;

  localparam int          INSTR_W       = 48;
  localparam int          IFQ_PC_W      = 16;
  localparam int          IFQ_DEPTH     = 4;
  localparam logic [15:0] IFQ_RESET_PC  = 16'h0000;
  // LLB R0,#0 encodes as all zeros.
  localparam logic [47:0] IFQ_NOP_INSTR = 48'h0;

  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/ifq_fifo.sv
// DEPTH x WIDTH synchronous FIFO with flush; head is read combinationally, so a
// push is visible one cycle later (no bypass). Caller guarantees no push-when-full.
module ifq_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_dat,
  input  logic                   pop,
  input  logic                   flush,
  output logic [WIDTH-1:0]       head_dat,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = push_dat;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_dat = mem_q[rd_ptr_q];
  assign count    = count_q;
  assign full     = (count_q == CNT_W'(DEPTH));
  assign empty    = (count_q == '0);

endmodule

// File: rtl/ifetch_queue.sv
// Fetch stage: owns PC, issues in-order requests under a queue credit, buffers
// responses for decode; head shown combinationally, stall holds it, NOP when empty.
module ifetch_queue
  import ifetch_queue_pkg::*;
#(
  parameter int                 PC_W      = IFQ_PC_W,
  parameter int                 DEPTH     = IFQ_DEPTH,
  parameter logic [PC_W-1:0]    RESET_PC  = PC_W'(IFQ_RESET_PC),
  parameter logic [INSTR_W-1:0] NOP_INSTR = IFQ_NOP_INSTR
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall_IM_ID,
  input  logic               flow_change_ID_EX,
  input  logic [PC_W-1:0]    dst_ID_EX,
  input  logic               hlt_fetch,
  output logic               im_req,
  output logic [PC_W-1:0]    im_addr,
  input  logic               im_gnt,
  input  logic               im_rvalid,
  input  logic [INSTR_W-1:0] im_rdata,
  output logic [INSTR_W-1:0] instr,
  output logic [PC_W-1:0]    nxt_pc,
  output logic               instr_vld
);

  localparam int CNT_W  = cnt_width(DEPTH);
  // Stale responses can pile up across back-to-back redirects with a slow memory.
  localparam int DISC_W = CNT_W + 4;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    nxt_pc;
  } ifq_entry_t;

  logic [PC_W-1:0]   pc_q, pc_d;
  logic [CNT_W-1:0]  outstanding_q, outstanding_d, outstanding_nx;
  logic [DISC_W-1:0] discard_q, discard_d, discard_nx;
  logic              halted_q, halted_d;
  logic              req_q, req_d;
  logic              gnt_acc, resp_live, resp_stale, push, pop;
  logic [CNT_W-1:0]  count, count_nx;
  logic              full, empty;
  ifq_entry_t        push_dat, head_dat;

  // Request is a flop of the credit rule evaluated on next state, so it is
  // quiet in reset and cannot change while waiting for a grant.
  assign im_req  = req_q & ~flow_change_ID_EX & ~hlt_fetch;
  assign im_addr = pc_q;

  assign gnt_acc    = im_req & im_gnt;
  assign resp_stale = im_rvalid & (discard_q != '0);
  assign resp_live  = im_rvalid & (discard_q == '0);
  assign push       = resp_live & ~flow_change_ID_EX;
  assign pop        = ~stall_IM_ID & ~empty & ~flow_change_ID_EX;

  assign push_dat.instr  = im_rdata;
  assign push_dat.nxt_pc = pc_of_resp();

  always_comb begin
    outstanding_nx = outstanding_q + CNT_W'(gnt_acc) - CNT_W'(resp_live);
    discard_nx     = discard_q - DISC_W'(resp_stale);
    count_nx       = flow_change_ID_EX ? '0 : count + CNT_W'(push) - CNT_W'(pop);
    halted_d       = halted_q | hlt_fetch;
    pc_d           = pc_q;
    outstanding_d  = outstanding_nx;
    discard_d      = discard_nx;
    if (flow_change_ID_EX) begin
      pc_d          = dst_ID_EX;
      outstanding_d = '0;
      discard_d     = discard_nx + DISC_W'(outstanding_nx);
    end else if (gnt_acc) begin
      pc_d = pc_q + PC_W'(1);
    end
    req_d = ~halted_d &
            (({1'b0, count_nx} + {1'b0, outstanding_d}) < (CNT_W + 1)'(DEPTH));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q          <= RESET_PC;
      outstanding_q <= '0;
      discard_q     <= '0;
      halted_q      <= 1'b0;
      req_q         <= 1'b0;
    end else begin
      pc_q          <= pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      halted_q      <= halted_d;
      req_q         <= req_d;
    end
  end

  // Responses return in order, so the live one belongs to the oldest live
  // request: PC minus the live requests still in flight.
  function automatic logic [PC_W-1:0] pc_of_resp();
    return pc_q - PC_W'(outstanding_q) + PC_W'(1);
  endfunction

  ifq_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (INSTR_W + PC_W)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .push_dat (push_dat),
    .pop      (pop),
    .flush    (flow_change_ID_EX),
    .head_dat (head_dat),
    .count    (count),
    .full     (full),
    .empty    (empty)
  );

  assign instr     = empty ? NOP_INSTR : head_dat.instr;
  assign nxt_pc    = empty ? '0 : head_dat.nxt_pc;
  assign instr_vld = ~empty;

  a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n) !(push && full));
  a_no_underflow : assert property (@(posedge clk) disable iff (!rst_n)
    !(im_rvalid && outstanding_q == '0 && discard_q == '0));

endmodule

// File: tb/tb_ifetch_queue.sv
// Directed bench for ifetch_queue with an in-order variable-latency memory model
// and a log of instructions consumed by decode.
module tb_ifetch_queue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall_IM_ID, flow_change_ID_EX, hlt_fetch;
  logic [15:0] dst_ID_EX;
  logic        im_req, im_gnt, im_rvalid;
  logic [15:0] im_addr;
  logic [47:0] im_rdata;
  logic [47:0] instr;
  logic [15:0] nxt_pc;
  logic        instr_vld;

  always #5 clk = ~clk;

  ifetch_queue dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .stall_IM_ID       (stall_IM_ID),
    .flow_change_ID_EX (flow_change_ID_EX),
    .dst_ID_EX         (dst_ID_EX),
    .hlt_fetch         (hlt_fetch),
    .im_req            (im_req),
    .im_addr           (im_addr),
    .im_gnt            (im_gnt),
    .im_rvalid         (im_rvalid),
    .im_rdata          (im_rdata),
    .instr             (instr),
    .nxt_pc            (nxt_pc),
    .instr_vld         (instr_vld)
  );

  typedef struct {
    logic [15:0] addr;
    int          due;
  } pend_t;

  pend_t       pend[$];
  logic [47:0] dlv_i[$];
  logic [15:0] dlv_p[$];
  int          cyc, lat, n_gnt;
  int          n_checks = 0;
  int          n_errors = 0;

  function automatic logic [47:0] word(input logic [15:0] a);
    return {16'hC0DE, a, ~a};
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_dlv(input string tag, input int idx, input logic [15:0] addr);
    if (idx < dlv_i.size()) begin
      check_eq({tag, "_instr"}, 64'(dlv_i[idx]), 64'(word(addr)));
      check_eq({tag, "_nxt_pc"}, 64'(dlv_p[idx]), 64'(16'(addr + 16'd1)));
    end else begin
      check_eq({tag, "_count"}, 64'(dlv_i.size()), 64'(idx + 1));
    end
  endtask

  task automatic drive(input logic st, input logic gn, input logic fc,
                       input logic [15:0] d, input logic h);
    stall_IM_ID       = st;
    im_gnt            = gn;
    flow_change_ID_EX = fc;
    dst_ID_EX         = d;
    hlt_fetch         = h;
    #1;
  endtask

  // Records this cycle's grant and consumption, then opens the next cycle
  // with the memory's response for it.
  task automatic tick();
    pend_t p;
    if (im_req && im_gnt) begin
      p.addr = im_addr;
      p.due  = cyc + lat;
      pend.push_back(p);
      n_gnt++;
    end
    if (instr_vld && !stall_IM_ID && !flow_change_ID_EX) begin
      dlv_i.push_back(instr);
      dlv_p.push_back(nxt_pc);
    end
    @(negedge clk);
    cyc++;
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      im_rvalid = 1'b1;
      im_rdata  = word(pend[0].addr);
      void'(pend.pop_front());
    end else begin
      im_rvalid = 1'b0;
      im_rdata  = 48'hBAD0_BAD0_BAD0;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      drive(1'b0, 1'b1, 1'b0, 16'h0, 1'b0);
      tick();
    end
  endtask

  task automatic do_reset(input int l);
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
    im_rvalid = 1'b0;
    im_rdata  = 48'h0;
    pend.delete();
    dlv_i.delete();
    dlv_p.delete();
    n_gnt = 0;
    lat   = l;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cyc   = 0;
  endtask

  initial begin
    rst_n = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
    im_rvalid = 1'b0;
    im_rdata  = 48'h0;
    lat = 1; cyc = 0; n_gnt = 0;
    rst_n = 1'b0;
    #12;
    check_eq("rst_im_req", 64'(im_req), 64'(0));
    check_eq("rst_instr", 64'(instr), 64'(0));
    check_eq("rst_nxt_pc", 64'(nxt_pc), 64'(0));
    check_eq("rst_vld", 64'(instr_vld), 64'(0));

    // Streaming with a 1-cycle memory.
    do_reset(1);
    for (int c = 0; c < 10; c++) begin
      drive(1'b0, 1'b1, 1'b0, 16'h0, 1'b0);
      if (c == 0) check_eq("s_req_c0", 64'(im_req), 64'(0));
      if (c >= 1 && c <= 4) begin
        check_eq("s_req", 64'(im_req), 64'(1));
        check_eq("s_addr", 64'(im_addr), 64'(c - 1));
      end
      if (c == 2) check_eq("s_vld_c2", 64'(instr_vld), 64'(0));
      if (c == 3) begin
        check_eq("s_vld_c3", 64'(instr_vld), 64'(1));
        check_eq("s_instr_c3", 64'(instr), 64'(word(16'h0)));
        check_eq("s_nxt_c3", 64'(nxt_pc), 64'(1));
      end
      tick();
    end
    for (int i = 0; i < 6; i++) check_dlv("s_dlv", i, 16'(i));

    // Decode stalled for 6 cycles: credit caps requests at the queue depth.
    do_reset(1);
    for (int c = 0; c < 6; c++) begin
      drive(1'b1, 1'b1, 1'b0, 16'h0, 1'b0);
      if (c == 3) check_eq("st_instr_c3", 64'(instr), 64'(word(16'h0)));
      if (c == 5) begin
        check_eq("st_gnts", 64'(n_gnt), 64'(4));
        check_eq("st_req_c5", 64'(im_req), 64'(0));
        check_eq("st_instr_c5", 64'(instr), 64'(word(16'h0)));
        check_eq("st_nxt_c5", 64'(nxt_pc), 64'(1));
      end
      tick();
    end
    check_eq("st_none_consumed", 64'(dlv_i.size()), 64'(0));
    run(14);
    for (int i = 0; i < 8; i++) check_dlv("st_dlv", i, 16'(i));

    // Latency 3 with grant withheld for two cycles.
    do_reset(3);
    for (int c = 0; c < 8; c++) begin
      drive(1'b0, (c >= 3), 1'b0, 16'h0, 1'b0);
      if (c == 1 || c == 2) begin
        check_eq("g_req_held", 64'(im_req), 64'(1));
        check_eq("g_addr_held", 64'(im_addr), 64'(0));
      end
      if (c == 6) begin
        check_eq("g_vld_c6", 64'(instr_vld), 64'(0));
        check_eq("g_nop_c6", 64'(instr), 64'(0));
        check_eq("g_nxt_c6", 64'(nxt_pc), 64'(0));
      end
      if (c == 7) begin
        check_eq("g_vld_c7", 64'(instr_vld), 64'(1));
        check_eq("g_instr_c7", 64'(instr), 64'(word(16'h0)));
        check_eq("g_req_c7", 64'(im_req), 64'(0));
      end
      tick();
    end
    run(20);
    for (int i = 0; i < 6; i++) check_dlv("g_dlv", i, 16'(i));

    // Redirect to 0x40 with 3 in flight; the one arriving that cycle is dropped too.
    do_reset(3);
    for (int c = 0; c < 10; c++) begin
      drive(1'b0, 1'b1, (c == 4), 16'h0040, 1'b0);
      if (c == 4) check_eq("r_req_c4", 64'(im_req), 64'(0));
      if (c == 5) begin
        check_eq("r_req_c5", 64'(im_req), 64'(1));
        check_eq("r_addr_c5", 64'(im_addr), 64'h40);
      end
      if (c == 8) check_eq("r_vld_c8", 64'(instr_vld), 64'(0));
      if (c == 9) begin
        check_eq("r_instr_c9", 64'(instr), 64'(word(16'h0040)));
        check_eq("r_nxt_c9", 64'(nxt_pc), 64'h41);
      end
      tick();
    end
    run(10);
    for (int i = 0; i < 4; i++) check_dlv("r_dlv", i, 16'(16'h40 + i));

    // Redirect on a response, then a second redirect to 0x80 two cycles later.
    do_reset(3);
    for (int c = 0; c < 12; c++) begin
      drive(1'b0, 1'b1, (c == 4 || c == 6), (c == 6) ? 16'h0080 : 16'h0040, 1'b0);
      if (c == 6) check_eq("rr_req_c6", 64'(im_req), 64'(0));
      if (c == 7) check_eq("rr_addr_c7", 64'(im_addr), 64'h80);
      if (c == 10) check_eq("rr_vld_c10", 64'(instr_vld), 64'(0));
      if (c == 11) begin
        check_eq("rr_instr_c11", 64'(instr), 64'(word(16'h0080)));
        check_eq("rr_nxt_c11", 64'(nxt_pc), 64'h81);
      end
      tick();
    end
    run(8);
    for (int i = 0; i < 3; i++) check_dlv("rr_dlv", i, 16'(16'h80 + i));

    // Halt at pc=5 with 2 in flight: those drain, then bubbles forever.
    do_reset(2);
    for (int c = 0; c < 16; c++) begin
      drive(1'b0, 1'b1, 1'b0, 16'h0, (c == 6));
      if (c == 6) begin
        check_eq("h_pc_c6", 64'(im_addr), 64'(5));
        check_eq("h_req_c6", 64'(im_req), 64'(0));
      end
      tick();
    end
    check_eq("h_gnts", 64'(n_gnt), 64'(5));
    check_eq("h_req_end", 64'(im_req), 64'(0));
    check_eq("h_dlv_count", 64'(dlv_i.size()), 64'(5));
    check_dlv("h_dlv_last", 4, 16'h4);
    check_eq("h_vld_end", 64'(instr_vld), 64'(0));
    check_eq("h_nop_end", 64'(instr), 64'(0));
    check_eq("h_nxt_end", 64'(nxt_pc), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
